// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory controller.
//   - funct3 codes for the supported loads/stores
//   - FSM state type
//   - byte-enable width
//   - lsu_legal(): alignment and funct3 legality check for one access
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int unsigned BeW = 4;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StResp,
        StErr
    } lsu_state_t;

    // Stores share lb/lh/lw encodings; unsigned variants exist only for loads.
    function automatic logic lsu_legal(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = !off[0];
            F3_LW:   ok = (off == 2'b00);
            F3_LBU:  ok = !we;
            F3_LHU:  ok = !we && !off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational load-data formatter.
//   rdata  : raw 32-bit word from memory
//   off    : byte offset within the word (addr[1:0])
//   funct3 : load type; bit 2 selects zero extension
//   data   : lane-selected, sign/zero-extended result
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sext;

    always_comb begin
        shifted   = rdata >> {off, 3'b000};
        byte_lane = shifted[7:0];
        half_lane = off[1] ? rdata[31:16] : rdata[15:0];
        sext      = !funct3[2];
        case (funct3[1:0])
            2'b00:   data = {{24{sext & byte_lane[7]}}, byte_lane};
            2'b01:   data = {{16{sext & half_lane[15]}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the memory stage and a single-port data memory.
// Accepts one access at a time, rejects misaligned/illegal accesses without
// touching memory, waits for a variable-latency response and returns either
// an extended load result or a store acknowledge as a one-cycle pulse.
//
// Build option: define LSU_TIMEOUT_EN to enable a watchdog that aborts an
// access with rsp_err after TIMEOUT_CYCLES cycles in REQ/WAIT.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/ready/we/funct3/addr/wdata   request from the memory stage
//   rsp_valid/rdata/err        one-cycle response, no backpressure
//   mem_req/gnt/we/addr/be/wdata           memory request channel
//   mem_rvalid/rdata           memory response channel
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [2:0]     req_funct3,
    input  logic [AW-1:0]  req_addr,
    input  logic [DW-1:0]  req_wdata,
    output logic           rsp_valid,
    output logic [DW-1:0]  rsp_rdata,
    output logic           rsp_err,
    output logic           mem_req,
    input  logic           mem_gnt,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [BeW-1:0] mem_be,
    output logic [DW-1:0]  mem_wdata,
    input  logic           mem_rvalid,
    input  logic [DW-1:0]  mem_rdata
);

    lsu_state_t    state_q, state_d;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] ext_data;
    logic          accept;
    logic          timeout;

    assign accept = (state_q == StIdle) && req_valid;

    lsu_load_extract u_extract (
        .rdata  (mem_rdata),
        .off    (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (ext_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q;

    // Counts every cycle spent in REQ and WAIT as one continuous budget.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == StReq || state_q == StWait) begin
            cnt_q <= cnt_q + CntW'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state_q == StWait && mem_rvalid) begin
                rdata_q <= we_q ? '0 : ext_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = lsu_legal(req_we, req_funct3, req_addr[1:0]) ? StReq : StErr;
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    state_d = StWait;
                end else if (timeout) begin
                    state_d = StErr;
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    state_d = StResp;
                end else if (timeout) begin
                    state_d = StErr;
                end
            end
            StResp:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Memory-side fields are zero outside REQ so nothing leaks between accesses.
    always_comb begin
        req_ready = (state_q == StIdle);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        rsp_valid = (state_q == StResp) || (state_q == StErr);
        rsp_err   = (state_q == StErr);
        rsp_rdata = (state_q == StResp) ? rdata_q : '0;
        if (state_q == StReq) begin
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = {addr_q[AW-1:2], 2'b00};
            case (funct3_q[1:0])
                2'b00: begin
                    mem_be    = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    mem_be    = 4'b0011 << addr_q[1:0];
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = wdata_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl. Cycle numbering: cyc counts rising edges; an access
// accepted at edge e_t has its first REQ cycle at cyc == e_t.
module tb_lsu_mem_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    lsu_mem_ctrl #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Expected transaction, filled in by the stimulus code.
    bit          chk_en = 0;
    bit          act = 0;
    int          e_t, e_mhi, e_rsp, e_end;
    logic        e_we, e_err;
    logic [31:0] e_addr, e_wd, e_rdata;
    logic [3:0]  e_be;

    // Observations gathered by the compare process.
    int          mreq_cnt, rsp_cnt, last_rsp_cyc;
    logic [31:0] last_rdata, last_addr, last_wd;
    logic        last_err, last_we;
    logic [3:0]  last_be;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    // Reference model: plain arithmetic on access size and byte offset.
    function automatic int unsigned m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic f3_ok;
        f3_ok = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return f3_ok && ((a % m_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned n;
        n = m_size(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
        case (m_size(f3))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int unsigned n;
        logic [31:0] mask, v;
        n    = m_size(f3);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
        v    = (rd >> (8 * (a % 4))) & mask;
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // Compare process: every cycle after reset.
    always @(negedge clk) begin
        if (chk_en) begin
            bit busy, exp_mreq, exp_rsp;
            busy     = act && cyc >= e_t && cyc <= e_end;
            exp_mreq = act && cyc >= e_t && cyc <= e_mhi;
            exp_rsp  = act && cyc == e_rsp;
            check("req_ready", {31'd0, req_ready}, {31'd0, !busy});
            check("mem_req", {31'd0, mem_req}, {31'd0, exp_mreq});
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp});
            if (exp_mreq && mem_req) begin
                check("mem_we", {31'd0, mem_we}, {31'd0, e_we});
                check("mem_addr", mem_addr, e_addr);
                check("mem_be", {28'd0, mem_be}, {28'd0, e_be});
                if (e_we) check("mem_wdata", mem_wdata, e_wd);
            end
            if (exp_rsp && rsp_valid) begin
                check("rsp_rdata", rsp_rdata, e_rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
            end
            if (mem_req) begin
                mreq_cnt++;
                last_addr = mem_addr;
                last_be   = mem_be;
                last_wd   = mem_wdata;
                last_we   = mem_we;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                last_rdata   = rsp_rdata;
                last_err     = rsp_err;
                last_rsp_cyc = cyc;
            end
        end
    end

    // Drive one access; gnt after g wait cycles, rvalid r cycles after the
    // first post-grant cycle. Called and returns at posedge+1 with the DUT idle.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int g, input int r);
        logic legal;
        legal  = m_legal(we, f3, a);
        e_t    = cyc + 1;
        e_we   = we;
        e_addr = {a[31:2], 2'b00};
        e_be   = m_be(f3, a);
        e_wd   = m_wd(f3, wd);
        if (!legal) begin
            e_mhi = e_t - 1; e_rsp = e_t; e_err = 1'b1; e_rdata = '0;
        end else begin
            e_mhi = e_t + g; e_rsp = e_t + g + 2 + r; e_err = 1'b0;
            e_rdata = we ? 32'd0 : m_load(f3, a, rd);
        end
        e_end = e_rsp; act = 1; mreq_cnt = 0; rsp_cnt = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        // Scramble request inputs to show the DUT uses latched values.
        req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd; req_funct3 = 3'b111;
        if (legal) begin
            for (int k = 0; k <= g; k++) begin
                mem_gnt    = (k == g);
                mem_rvalid = (k == 0 && g > 1);  // stray rvalid during REQ
                mem_rdata  = 32'h5A5A_5A5A;
                @(posedge clk); #1;
            end
            mem_gnt = 1'b0;
            for (int k = 0; k <= r; k++) begin
                mem_rvalid = (k == r);
                mem_rdata  = (k == r) ? rd : 32'hDEAD_0000;
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b0;
        end
        @(posedge clk); #1;
        // Stray rvalid while idle.
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        e_t = 0; e_mhi = -1; e_rsp = -1; e_end = -1; e_we = 0; e_err = 0;
        e_addr = '0; e_wd = '0; e_rdata = '0; e_be = '0;
        mreq_cnt = 0; rsp_cnt = 0; last_rsp_cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; chk_en = 1;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_mem_be", {28'd0, mem_be}, 32'd0);

        // lb 0x103: lane 3 = 0x80, sign-extended; response two cycles after first REQ cycle
        issue(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0);
        check("lb_rdata", last_rdata, 32'hFFFF_FF80);
        check("lb_latency", 32'(last_rsp_cyc - e_t), 32'd2);

        issue(1'b0, 3'b101, 32'h102, 32'h0, 32'h9ABC_0000, 0, 0);
        check("lhu_rdata", last_rdata, 32'h0000_9ABC);
        check("lhu_addr", last_addr, 32'h100);

        issue(1'b1, 3'b001, 32'h206, 32'hDEAD_BEEF, 32'h0, 0, 0);
        check("sh_be", {28'd0, last_be}, 32'hC);
        check("sh_wdata", last_wd, 32'hBEEF_BEEF);
        check("sh_we", {31'd0, last_we}, 32'd1);
        check("sh_rdata", last_rdata, 32'h0);

        issue(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
        check("lw_mis_err", {31'd0, last_err}, 32'd1);
        check("lw_mis_latency", 32'(last_rsp_cyc - e_t), 32'd0);
        check("lw_mis_no_mem", 32'(mreq_cnt), 32'd0);

        issue(1'b0, 3'b001, 32'h100, 32'h0, 32'h0000_8001, 5, 3);
        check("slow_mreq_cycles", 32'(mreq_cnt), 32'd6);
        check("slow_rsp_pulses", 32'(rsp_cnt), 32'd1);
        check("slow_lh_rdata", last_rdata, 32'hFFFF_8001);

        issue(1'b1, 3'b000, 32'h001, 32'h1234_56A5, 32'h0, 0, 1);
        check("sb_be", {28'd0, last_be}, 32'h2);
        check("sb_wdata", last_wd, 32'hA5A5_A5A5);

        issue(1'b1, 3'b010, 32'h010, 32'hCAFE_F00D, 32'h0, 1, 0);
        check("sw_be", {28'd0, last_be}, 32'hF);

        issue(1'b0, 3'b100, 32'h002, 32'h0, 32'h00AB_0000, 0, 0);
        check("lbu_rdata", last_rdata, 32'h0000_00AB);

        issue(1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 0);
        check("bad_f3_load_err", {31'd0, last_err}, 32'd1);
        issue(1'b1, 3'b100, 32'h000, 32'h0, 32'h0, 0, 0);
        check("bad_f3_store_err", {31'd0, last_err}, 32'd1);
        issue(1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 0, 0);
        check("sh_mis_err", {31'd0, last_err}, 32'd1);
        check("sh_mis_no_mem", 32'(mreq_cnt), 32'd0);

`ifdef LSU_TIMEOUT_EN
        // Never granted: TO cycles in REQ, then an error response.
        e_t = cyc + 1; e_mhi = e_t + TO - 1; e_rsp = e_t + TO; e_end = e_rsp;
        e_we = 1'b0; e_addr = 32'h20; e_be = 4'hF; e_err = 1'b1; e_rdata = '0;
        act = 1; mreq_cnt = 0; rsp_cnt = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (TO + 1) @(posedge clk);
        #1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check("timeout_mreq_cycles", 32'(mreq_cnt), 32'(TO));
        check("timeout_err", {31'd0, last_err}, 32'd1);
        check("timeout_rsp_pulses", 32'(rsp_cnt), 32'd1);
`endif

        // Reset while in WAIT: idle on the next edge, later rvalid ignored.
        e_t = cyc + 1; e_mhi = e_t; e_rsp = -100; e_end = e_t + 1;
        e_we = 1'b0; e_addr = 32'h40; e_be = 4'hF; e_err = 1'b0; e_rdata = '0;
        act = 1; mreq_cnt = 0; rsp_cnt = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_wait_ready", {31'd0, req_ready}, 32'd1);
        check("rst_wait_mem_req", {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
        check("rst_wait_no_rsp", 32'(rsp_cnt), 32'd0);

        issue(1'b0, 3'b010, 32'h008, 32'h0, 32'h1122_3344, 1, 2);
        check("post_rst_lw_rdata", last_rdata, 32'h1122_3344);

        act = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
